// File: rtl/mpu_table_writer.sv
// Second bus initiator that programs or invalidates one MPU table entry through the
// MPU's CPU-side write port; code_end is always the last word so the entry turns valid atomically.
module mpu_table_writer #(
  parameter int          MPU_START_ADDR = 768,
  parameter int          MPU_ITEM_NUM   = 16,
  parameter int          MPU_ITEM_LEN   = 5,
  parameter logic [31:0] TRUSTED_PC     = 32'h0000_0000,
  parameter int          TIMEOUT        = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [7:0]  cmd_index,
  input  logic [31:0] cmd_code_start,
  input  logic [31:0] cmd_code_end,
  input  logic [31:0] cmd_data_start,
  input  logic [31:0] cmd_data_end,
  input  logic [2:0]  cmd_access,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [21:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  output logic        bus_is_inst,
  output logic [31:0] bus_pc,
  input  logic        mpu_irq,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam int TO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  // Word order per operation; program ends on code_end (+2) which validates the entry.
  localparam logic [2:0] PROG_OFF [5] = '{3'd5, 3'd3, 3'd4, 3'd1, 3'd2};
  localparam logic [2:0] INV_OFF  [5] = '{3'd1, 3'd2, 3'd5, 3'd0, 3'd0};

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_ACK, RELEASE, DONE, ERR} state_t;

  state_t            state_reg, state_next;
  logic              op_reg, op_next;
  logic [7:0]        idx_reg, idx_next;
  logic [31:0]       code_start_reg, code_start_next;
  logic [31:0]       code_end_reg, code_end_next;
  logic [31:0]       data_start_reg, data_start_next;
  logic [31:0]       data_end_reg, data_end_next;
  logic [2:0]        access_reg, access_next;
  logic [2:0]        k_reg, k_next;
  logic [TO_W-1:0]   tmo_reg, tmo_next;
  logic [21:0]       addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [1:0]        err_code_reg, err_code_next;

  logic [19:0]       entry_base;
  logic [19:0]       slot_word [5];
  logic [31:0]       prog_data [5];
  logic [31:0]       slot_data [5];
  logic [2:0]        last_k;

  assign entry_base = 20'(MPU_START_ADDR + int'(idx_reg) * MPU_ITEM_LEN);

  assign prog_data[0] = {29'd0, access_reg};
  assign prog_data[1] = data_start_reg;
  assign prog_data[2] = data_end_reg;
  assign prog_data[3] = code_start_reg;
  assign prog_data[4] = code_end_reg;

  // Invalidation writes zeros everywhere, so only the address table differs.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_slot
      assign slot_word[gi] = entry_base + 20'(op_reg ? INV_OFF[gi] : PROG_OFF[gi]);
      assign slot_data[gi] = op_reg ? 32'd0 : prog_data[gi];
    end
  endgenerate

  assign last_k = op_reg ? 3'd2 : 3'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      op_reg         <= 1'b0;
      idx_reg        <= 8'd0;
      code_start_reg <= 32'd0;
      code_end_reg   <= 32'd0;
      data_start_reg <= 32'd0;
      data_end_reg   <= 32'd0;
      access_reg     <= 3'd0;
      k_reg          <= 3'd0;
      tmo_reg        <= '0;
      addr_reg       <= 22'd0;
      wdata_reg      <= 32'd0;
      err_code_reg   <= 2'd0;
    end else begin
      state_reg      <= state_next;
      op_reg         <= op_next;
      idx_reg        <= idx_next;
      code_start_reg <= code_start_next;
      code_end_reg   <= code_end_next;
      data_start_reg <= data_start_next;
      data_end_reg   <= data_end_next;
      access_reg     <= access_next;
      k_reg          <= k_next;
      tmo_reg        <= tmo_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      err_code_reg   <= err_code_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    op_next         = op_reg;
    idx_next        = idx_reg;
    code_start_next = code_start_reg;
    code_end_next   = code_end_reg;
    data_start_next = data_start_reg;
    data_end_next   = data_end_reg;
    access_next     = access_reg;
    k_next          = k_reg;
    tmo_next        = tmo_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    err_code_next   = err_code_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          op_next         = cmd_op;
          idx_next        = cmd_index;
          code_start_next = cmd_code_start;
          code_end_next   = cmd_code_end;
          data_start_next = cmd_data_start;
          data_end_next   = cmd_data_end;
          access_next     = cmd_access;
          err_code_next   = 2'd0;
          state_next      = CHECK;
        end
      end
      CHECK: begin
        if (int'(idx_reg) >= MPU_ITEM_NUM) begin
          err_code_next = 2'd1;
          state_next    = ERR;
        end else begin
          k_next     = 3'd0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        addr_next  = {slot_word[k_reg], 2'b00};
        wdata_next = slot_data[k_reg];
        tmo_next   = '0;
        state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        // An interrupt outranks a simultaneous ready: the write was refused.
        if (mpu_irq) begin
          err_code_next = 2'd2;
          state_next    = ERR;
        end else if (bus_ready) begin
          state_next = RELEASE;
        end else if (tmo_reg == TO_W'(TIMEOUT)) begin
          err_code_next = 2'd3;
          state_next    = ERR;
        end else begin
          tmo_next = tmo_reg + TO_W'(1);
        end
      end
      RELEASE: begin
        // The MPU only takes a new request once its ready has fallen.
        if (!bus_ready && !mpu_irq) begin
          if (k_reg == last_k) begin
            state_next = DONE;
          end else begin
            k_next     = k_reg + 3'd1;
            state_next = ISSUE;
          end
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign cmd_ready   = (state_reg == IDLE);
  assign bus_valid   = (state_reg == WAIT_ACK);
  assign bus_wstrb   = {4{bus_valid}};
  assign bus_addr    = addr_reg;
  assign bus_wdata   = wdata_reg;
  assign bus_is_inst = 1'b0;
  assign bus_pc      = TRUSTED_PC;
  assign done        = (state_reg == DONE);
  assign error       = (state_reg == ERR);
  assign err_code    = err_code_reg;

endmodule
